// File: rtl/datapath_dump_serializer.sv
// Snapshots a wide datapath debug bus on start and streams it to a UART
// write/done handshake as bytes, LSB byte first, with an optional leading sync byte.
module datapath_dump_serializer #(
  parameter int unsigned BUS_W     = 1401,
  parameter bit          SYNC_EN   = 1'b1,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BUS_W-1:0] bus,
  input  logic             tx_done,
  output logic             tx_write,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NBYTES = (BUS_W + 7) / 8;
  localparam int unsigned SH_W   = NBYTES * 8;
  localparam int unsigned IDX_W  = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, FIN} state_t;

  state_t           state_q, state_d;
  logic [SH_W-1:0]  shadow_q, shadow_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sync_q, sync_d;
  logic [7:0]       tx_data_d;
  logic             tx_write_d, busy_d, done_d;

  // Next-state logic; outputs are derived from the next state so they are registered
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    sync_d    = sync_q;
    tx_data_d = tx_data;
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d  = SH_W'(bus);
          idx_d     = '0;
          sync_d    = SYNC_EN;
          tx_data_d = SYNC_EN ? SYNC_BYTE : shadow_d[7:0];
          state_d   = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (!sync_q && idx_q == IDX_W'(NBYTES - 1)) begin
            state_d = FIN;
          end else begin
            // The sync slot is followed by payload byte 0 without moving the index
            if (sync_q) sync_d = 1'b0;
            else        idx_d  = idx_q + IDX_W'(1);
            tx_data_d = 8'(shadow_q >> {idx_d, 3'b000});
            state_d   = SEND;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tx_write_d = (state_d == SEND);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FIN);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      sync_q   <= 1'b0;
      tx_write <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      sync_q   <= sync_d;
      tx_write <= tx_write_d;
      tx_data  <= tx_data_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule
